// File: rtl/fetch_ctrl_pkg.sv
// Shared core definitions for the fetch front end: word width, NOP encoding
// and the fetch-queue entry layout.
package fetch_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Valid/ready handshake carrying fetched instructions toward decode.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;

  modport master (output out_valid, output out_inst, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_inst, input out_pc, output out_ready);

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; flush empties it and overrides push/pop.
module fetch_queue
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fetch_entry_t           entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t            mem_q [DEPTH];
  logic         [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic         [AW:0]     level_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: the level gates everything read from it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !rst) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives a combinational instruction memory and
// buffers {pc, inst} pairs in a small queue toward decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [XLEN-1:0]        imem_inst,
  input  logic                   halt,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  fetch_ctrl_if.master           dec,
  output logic [$clog2(DEPTH):0] q_level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            head_valid, pop, push;
  fetch_entry_t    head, new_entry;
  logic [LW-1:0]   level;

  assign head_valid = (level != '0);
  assign pop        = head_valid && dec.out_ready && !redirect_valid;
  assign push       = !halt && !redirect_valid && ((level != FULL_LVL) || pop);

  assign new_entry.pc   = fetch_pc_q;
  assign new_entry.inst = imem_inst;

  // Redirect targets are forced word-aligned.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) fetch_pc_d = redirect_pc & ~32'd3;
    else if (push)      fetch_pc_d = fetch_pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (new_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .head_o  (head),
    .level_o (level)
  );

  assign imem_addr     = fetch_pc_q;
  assign q_level       = level;
  assign dec.out_valid = head_valid;
  assign dec.out_inst  = head_valid ? head.inst : NOP;
  assign dec.out_pc    = head_valid ? head.pc   : '0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, streaming, backpressure, redirect,
// halt, PC wrap and mid-stream reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  q_level;

  int checks   = 0;
  int failures = 0;

  fetch_ctrl_if dec_if ();

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dec_if.master),
    .q_level        (q_level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'h0050_0093;
      30'd1:   return 32'h0030_0113;
      30'd2:   return 32'h0020_81B3;
      default: return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign imem_inst = inst_of(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(dec_if.out_valid), 32'd1);
    chk({tag, "_pc"},    dec_if.out_pc,         pc);
    chk({tag, "_inst"},  dec_if.out_inst,       inst_of(pc));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(dec_if.out_valid), 32'd0);
    chk({tag, "_inst"},  dec_if.out_inst,       32'h0000_0013);
    chk({tag, "_pc"},    dec_if.out_pc,         32'd0);
    chk({tag, "_lvl"},   32'(q_level),          32'd0);
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    dec_if.out_ready = 1'b1;
    tick(); tick();
    chk_empty("rst");
    chk("rst_addr", imem_addr, 32'd0);

    // streaming after reset
    rst = 1'b0;
    tick(); chk_head("run1", 32'd0);
    chk("run1_inst_lit", dec_if.out_inst, 32'h0050_0093);
    tick(); chk_head("run2", 32'd4);
    chk("run2_inst_lit", dec_if.out_inst, 32'h0030_0113);
    tick(); chk_head("run3", 32'd8);
    chk("run3_inst_lit", dec_if.out_inst, 32'h0020_81B3);
    chk("run3_addr", imem_addr, 32'd12);

    // backpressure from a fresh reset
    rst = 1'b1; tick();
    rst = 1'b0; dec_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_head("bp_hold", 32'd0);
    end
    chk("bp_lvl", 32'(q_level), 32'd2);
    chk("bp_addr", imem_addr, 32'd8);
    dec_if.out_ready = 1'b1;
    tick(); chk_head("drain1", 32'd4); chk("drain1_lvl", 32'(q_level), 32'd2);
    tick(); chk_head("drain2", 32'd8);
    tick(); chk_head("drain3", 32'd12); chk("drain3_lvl", 32'(q_level), 32'd2);

    // redirect while full; target is misaligned on purpose
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0016;
    tick();
    redirect_valid = 1'b0;
    chk_empty("redir");
    chk("redir_addr", imem_addr, 32'h14);
    tick(); chk_head("redir_next", 32'h14);

    // halt with two entries queued
    dec_if.out_ready = 1'b0;
    tick(); chk("halt_pre_lvl", 32'(q_level), 32'd2);
    halt = 1'b1; dec_if.out_ready = 1'b1;
    tick(); chk_head("halt_pop1", 32'h18); chk("halt_addr1", imem_addr, 32'h1C);
    tick(); chk_empty("halt_pop2");         chk("halt_addr2", imem_addr, 32'h1C);
    tick(); chk("halt_idle_valid", 32'(dec_if.out_valid), 32'd0);
    chk("halt_addr3", imem_addr, 32'h1C);
    halt = 1'b0;
    tick(); chk_head("resume", 32'h1C);

    // redirect has priority over halt
    halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    halt = 1'b0; redirect_valid = 1'b0;
    chk_empty("redir_halt");
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick(); chk_head("wrap1", 32'hFFFF_FFFC); chk("wrap_addr1", imem_addr, 32'd0);
    tick(); chk_head("wrap2", 32'd0);

    // reset mid-stream
    rst = 1'b1;
    tick(); chk_empty("mid_rst"); chk("mid_rst_addr", imem_addr, 32'd0);
    rst = 1'b0;
    tick(); chk_head("post_rst", 32'd0); chk("post_rst_lvl", 32'(q_level), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning fetch-queue entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_addr  output  32  byte address to the combinational instruction memory.
REQ-006 SHALL have port imem_inst  input  32  instruction returned by memory for imem_addr, same cycle.
REQ-007 SHALL have port halt  input  1  suspend fetching while high.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-009 SHALL have port redirect_pc  input  32  redirect target.
REQ-010 SHALL have port out_valid  output  1  queue head valid toward decode.
REQ-011 SHALL have port out_ready  input  1  decode accepts head.
REQ-012 SHALL have port out_inst  output  32  head instruction.
REQ-013 SHALL have port out_pc  output  32  head PC.
REQ-014 SHALL have port q_level  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 SHALL drive imem_addr = fetch_pc register at all times; the memory drops bits [1:0].
REQ-016 SHALL push {fetch_pc, imem_inst} and advance fetch_pc by 4 on a rising edge when fetch_en = !halt && !redirect_valid && (q_level < DEPTH || pop).
REQ-017 SHALL define pop = out_valid && out_ready; the head is removed on that edge.
REQ-018 SHALL allow simultaneous push and pop when full; occupancy then stays DEPTH.
REQ-019 SHALL hold fetch_pc and not push while halt is high; pops still proceed.
REQ-020 SHALL, on redirect_valid at an edge, empty the queue, discard any pop/push that cycle, and load fetch_pc = {redirect_pc[31:2], 2'b00}; redirect has priority over halt, push and pop.
REQ-021 SHALL present out_valid = (q_level != 0) as a registered-state function, with out_inst/out_pc taken from the head entry.
REQ-022 SHALL drive out_inst = NOP (32'h0000_0013) and out_pc = 0 when out_valid is low.
REQ-023 SHALL keep out_valid, out_inst and out_pc stable while out_valid && !out_ready, absent redirect.
REQ-024 SHALL wrap fetch_pc modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-025 SHALL have one-cycle fetch-to-output latency: an instruction pushed at edge N is visible at out_* after edge N.
REQ-026 SHALL sustain one instruction per cycle when out_ready stays high and halt is low.

Reset
REQ-027 SHALL, while rst is high at an edge, set fetch_pc = RESET_PC, q_level = 0, out_valid = 0, out_inst = NOP, out_pc = 0, overriding all other inputs.
REQ-028 SHALL discard queued instructions when reset is asserted mid-operation; no stale entry appears after reset release.
REQ-029 SHALL push the instruction at RESET_PC on the first edge after rst deasserts (halt low).

Structure
REQ-030 SHALL take XLEN (32), NOP encoding (32'h0000_0013) and the queue entry struct {pc, inst} from the shared core package.
REQ-031 SHALL implement the queue as sub-module fetch_queue (synchronous FIFO with push, pop, flush, level), instantiated once.
REQ-032 SHALL contain no memory array for instructions; the instruction memory stays external.

Verification
REQ-033 SHALL cover reset then run: memory holds 0x00500093, 0x00300113, 0x002081B3 at words 0-2, out_ready=1 -> out_pc 0,4,8 with those instructions on consecutive cycles after edges 1,2,3.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles -> q_level saturates at DEPTH, fetch_pc stops at 8, head stays pc 0 / 0x00500093; release -> in-order drain without loss or duplication.
REQ-035 SHALL cover redirect: redirect_valid for one cycle with redirect_pc=32'h0000_0016 while queue full and out_ready=1 -> next cycle out_valid=0, q_level=0; following cycle out_pc=0x14.
REQ-036 SHALL cover halt: halt=1 with 2 entries queued, out_ready=1 -> two pops, then out_valid=0, imem_addr constant; halt=0 resumes at the held PC.
REQ-037 SHALL cover wrap and reset: redirect to 32'hFFFF_FFFC -> next out_pc 0xFFFF_FFFC then 0x0; rst asserted mid-stream -> out_valid=0, imem_addr=RESET_PC on the following cycle.
